uart_rx: RTL and testbench
==========================

// Module: uart_rx
// PURPOSE
//  UART receiver with parity checking and word packing. Deserialises 8E1-style frames from the
//  async line rx: start bit, BITS_PER_WORD data bits LSB first, even-parity bit, stop bit.
//  It packs NUM_WORDS consecutive good words into one W_OUT-bit output beat.
//  Sits between the board RX pin and a streaming consumer. There is no backpressure.
// PARAMETERS
//  CLOCKS_PER_PULSE  16  clk cycles per UART bit (baud divisor); must be >= 4
//  BITS_PER_WORD     8   data bits per UART frame
//  W_OUT             16  output width; must be an integer multiple of BITS_PER_WORD
//  NUM_WORDS (local) W_OUT/BITS_PER_WORD  frames packed per output beat
// PORTS
//  clk      in   1      single system clock; all logic on posedge
//  rstn     in   1      asynchronous, active-HIGH reset (rstn=1 resets; name kept per codebase)
//  rx       in   1      serial line, idle high; asynchronous to clk
//  m_valid  out  1      one-cycle pulse: m_data holds a complete packed beat
//  m_data   out  W_OUT  packed beat; word k (k-th frame received) occupies bits [k*BPW +: BPW]
// BEHAVIOUR
//  - Reset: m_valid=0, m_data=0, word count=0, FSM=IDLE, synchroniser flops=1 (line idle).
//  - rx passes through a 2-flop synchroniser before use. All timing below is on the synced rx.
//  - FSM states: IDLE, START, DATA, PARITY, STOP.
//    IDLE: wait for synced rx==0. Load the bit counter with CLOCKS_PER_PULSE/2-1. Go to START.
//    START: on counter expiry (mid start bit) sample rx.
//      rx==1 -> glitch; return to IDLE with no state change.
//      rx==0 -> reload counter with CLOCKS_PER_PULSE-1; go to DATA.
//    DATA: sample at each counter expiry (every CLOCKS_PER_PULSE clks, mid-bit).
//      Shift the sample into bit [i] for i=0..BPW-1 (LSB first). After BPW samples go to PARITY.
//    PARITY: sample the parity bit. Frame parity is ok iff sample == ^data (even parity).
//      Go to STOP.
//    STOP: sample mid stop bit, then return to IDLE immediately. The next start edge is
//      detectable from the second half of the stop bit, allowing back-to-back frames.
//  - Good frame (parity ok AND stop==1): write the word into slot word_cnt of the packing
//    register. word_cnt==NUM_WORDS-1 -> m_data <= full packed value, m_valid=1 on the next
//    clk for exactly one cycle, word_cnt <= 0. Otherwise word_cnt++.
//  - Bad frame (parity error or stop==0): discard the word and the partial beat (word_cnt <= 0).
//    m_data unchanged, no m_valid.
//  - m_data holds its last value between pulses. It updates only in the cycle m_valid rises.
//  - Latency: m_valid rises 1 clk after the final stop-bit sample. That is ~CPP/2+3 clks after
//    the stop bit starts on raw rx, including 2 synchroniser clks.
//  - Arbitrary idle gaps (0..N clks) between frames and between beats are legal.
//  - Asserting reset mid-frame aborts immediately. The partial frame and beat are lost.
//    The receiver waits for a fresh falling edge after release.
//  - rx stuck low: after a bad-stop discard the FSM re-enters START on the still-low line.
//    Each such frame is discarded (stop==0). No output until rx returns high.
// TESTING
//  1 Reset 2 clks then release; rx idle 1 -> m_valid stays 0, m_data==0.
//  2 Send frames 0xA5 (parity 0) then 0x3C (parity 0), CPP=16, random gaps 1-20 clks
//    -> single m_valid pulse, m_data==16'h3CA5.
//  3 10 random 16-bit beats as byte pairs, gaps up to 100 clks -> 10 pulses, each m_data == sent.
//  4 Byte 0x01 sent with parity bit 0 (wrong), then 0x12,0x34 correct
//    -> first discarded; one pulse with m_data==16'h3412.
//  5 Low glitch of 4 clks on idle rx, then 0xFF,0x00 -> glitch ignored; m_data==16'h00FF.
//  6 Assert rstn mid-data of second byte, release, send 0xBE,0xEF
//    -> no pulse before; m_data==16'hEFBE.

Source files
------------

// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchroniser, start/data/even-parity/stop deserialiser, and packing of
// NUM_WORDS good words into one W_OUT-bit beat announced by a single-cycle m_valid pulse.
module uart_rx #(
  parameter int CLOCKS_PER_PULSE = 16,
  parameter int BITS_PER_WORD    = 8,
  parameter int W_OUT            = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             rx,
  output logic             m_valid,
  output logic [W_OUT-1:0] m_data,
  output logic [2:0]       dbg_state
);
  // Stream out: m_valid is a one-cycle strobe with m_data stable in that cycle; no ready exists,
  // so the consumer must accept every beat the cycle it is strobed.
  localparam int NUM_WORDS = W_OUT / BITS_PER_WORD;
  localparam int CW = (CLOCKS_PER_PULSE > 1) ? $clog2(CLOCKS_PER_PULSE) : 1;
  localparam int IW = (BITS_PER_WORD > 1) ? $clog2(BITS_PER_WORD) : 1;
  localparam int WW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [CW-1:0] HALF      = CW'(CLOCKS_PER_PULSE / 2 - 1);
  localparam logic [CW-1:0] FULL      = CW'(CLOCKS_PER_PULSE - 1);
  localparam logic [IW-1:0] LAST_BIT  = IW'(BITS_PER_WORD - 1);
  localparam logic [WW-1:0] LAST_WORD = WW'(NUM_WORDS - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t                   state_q, state_d;
  logic                     rx_meta_q, rx_meta_d;
  logic                     rx_sync_q, rx_sync_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic [IW-1:0]            bit_q, bit_d;
  logic [BITS_PER_WORD-1:0] data_q, data_d;
  logic                     par_ok_q, par_ok_d;
  logic [WW-1:0]            word_q, word_d;
  logic [W_OUT-1:0]         pack_q, pack_d;
  logic                     m_valid_q, m_valid_d;
  logic [W_OUT-1:0]         m_data_q, m_data_d;

  always_comb begin
    state_d   = state_q;
    rx_meta_d = rx;
    rx_sync_d = rx_meta_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    data_d    = data_q;
    par_ok_d  = par_ok_q;
    word_d    = word_q;
    pack_d    = pack_q;
    m_valid_d = 1'b0;
    m_data_d  = m_data_q;
    case (state_q)
      IDLE: begin
        if (!rx_sync_q) begin
          cnt_d   = HALF;
          state_d = START;
        end
      end
      START: begin
        if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
        else if (rx_sync_q) state_d = IDLE;  // line back high mid start bit: a glitch
        else begin
          cnt_d   = FULL;
          bit_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
        else begin
          data_d[bit_q] = rx_sync_q;
          cnt_d         = FULL;
          if (bit_q == LAST_BIT) state_d = PARITY;
          else bit_d = bit_q + IW'(1);
        end
      end
      PARITY: begin
        if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
        else begin
          par_ok_d = (rx_sync_q == ^data_q);
          cnt_d    = FULL;
          state_d  = STOP;
        end
      end
      STOP: begin
        if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
        else begin
          // Leaving at mid stop bit lets the next start edge be seen in its second half.
          state_d = IDLE;
          if (par_ok_q && rx_sync_q) begin
            pack_d[int'(word_q)*BITS_PER_WORD +: BITS_PER_WORD] = data_q;
            if (word_q == LAST_WORD) begin
              m_data_d  = pack_d;
              m_valid_d = 1'b1;
              word_d    = '0;
            end else begin
              word_d = word_q + WW'(1);
            end
          end else begin
            word_d = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      state_q   <= IDLE;
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      cnt_q     <= '0;
      bit_q     <= '0;
      data_q    <= '0;
      par_ok_q  <= 1'b0;
      word_q    <= '0;
      pack_q    <= '0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
    end else begin
      state_q   <= state_d;
      rx_meta_q <= rx_meta_d;
      rx_sync_q <= rx_sync_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      data_q    <= data_d;
      par_ok_q  <= par_ok_d;
      word_q    <= word_d;
      pack_q    <= pack_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
    end
  end

  assign m_valid   = m_valid_q;
  assign m_data    = m_data_q;
  assign dbg_state = state_q;
endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: table of byte pairs with hand-computed packed beats, plus hand-written
// sequences for parity error, start glitch and mid-frame reset.
module tb_uart_rx;
  localparam int CPP = 16;

  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic        rx = 1'b1;
  logic        m_valid;
  logic [15:0] m_data;
  logic [2:0]  dbg_state;

  int n_cmp = 0;
  int n_fail = 0;
  logic [15:0] exp_q[$];
  logic [15:0] got_q[$];
  int rd_idx = 0;

  typedef struct packed {
    logic [7:0]  lo;
    logic [7:0]  hi;
    logic [15:0] exp;
  } vec_t;
  vec_t vecs[10];

  uart_rx #(.CLOCKS_PER_PULSE(CPP), .BITS_PER_WORD(8), .W_OUT(16)) dut (
    .clk(clk), .rstn(rstn), .rx(rx),
    .m_valid(m_valid), .m_data(m_data), .dbg_state(dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Output capture, sampled on the falling edge
  always @(negedge clk) begin
    if (m_valid) got_q.push_back(m_data);
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Driver tasks
  task automatic send_bit(input logic b);
    rx = b;
    repeat (CPP) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic bad_par);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit((^d) ^ bad_par);
    send_bit(1'b1);
  endtask

  task automatic gap(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // Scoreboard drain: bounded wait for the expected beats, then check count, values and hold.
  task automatic drain(input string name);
    int t;
    int n;
    t = 0;
    n = exp_q.size();
    while (got_q.size() < rd_idx + n && t < 3000) begin
      @(negedge clk);
      t++;
    end
    repeat (40) @(negedge clk);
    check({name, "_pulses"}, got_q.size() - rd_idx, n);
    for (int i = 0; i < n; i++) begin
      if (rd_idx < got_q.size()) begin
        check({name, "_data"}, got_q[rd_idx], exp_q[i]);
        rd_idx++;
      end
    end
    if (n > 0) check({name, "_hold"}, m_data, exp_q[n-1]);
    rd_idx = got_q.size();
    exp_q.delete();
  endtask

  initial begin
    vecs[0] = '{lo: 8'h34, hi: 8'h12, exp: 16'h1234};
    vecs[1] = '{lo: 8'h00, hi: 8'h00, exp: 16'h0000};
    vecs[2] = '{lo: 8'hFF, hi: 8'hFF, exp: 16'hFFFF};
    vecs[3] = '{lo: 8'h01, hi: 8'h80, exp: 16'h8001};
    vecs[4] = '{lo: 8'hEF, hi: 8'hBE, exp: 16'hBEEF};
    vecs[5] = '{lo: 8'h55, hi: 8'hAA, exp: 16'hAA55};
    vecs[6] = '{lo: 8'h7E, hi: 8'h81, exp: 16'h817E};
    vecs[7] = '{lo: 8'hC3, hi: 8'h3C, exp: 16'h3CC3};
    vecs[8] = '{lo: 8'h0F, hi: 8'hF0, exp: 16'hF00F};
    vecs[9] = '{lo: 8'h69, hi: 8'h96, exp: 16'h9669};

    // 1: reset state and idle line
    repeat (2) @(negedge clk);
    rstn = 1'b0;
    repeat (50) @(negedge clk);
    check("reset_m_valid", m_valid, 0);
    check("reset_m_data", m_data, 0);
    check("reset_state", dbg_state, 0);
    drain("idle");

    // 2: A5 then 3C with small random gaps
    gap($urandom_range(1, 20));
    send_frame(8'hA5, 1'b0);
    gap($urandom_range(1, 20));
    send_frame(8'h3C, 1'b0);
    exp_q.push_back(16'h3CA5);
    drain("pair");

    // 3: table of beats, gaps up to 100 clks (0 gap exercises back-to-back frames)
    for (int i = 0; i < 10; i++) begin
      gap($urandom_range(0, 100));
      send_frame(vecs[i].lo, 1'b0);
      gap((i == 3) ? 0 : $urandom_range(0, 100));
      send_frame(vecs[i].hi, 1'b0);
      exp_q.push_back(vecs[i].exp);
    end
    drain("table");

    // 4: wrong parity discards the word, next two pack cleanly
    gap(10);
    send_frame(8'h01, 1'b1);
    gap(5);
    send_frame(8'h12, 1'b0);
    gap(5);
    send_frame(8'h34, 1'b0);
    exp_q.push_back(16'h3412);
    drain("parity_err");

    // 4b: lone good byte followed by a bad stop bit drops the partial beat
    gap(10);
    send_frame(8'h77, 1'b0);
    gap(5);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b0);
    gap(3 * CPP);
    send_frame(8'h21, 1'b0);
    send_frame(8'h43, 1'b0);
    exp_q.push_back(16'h4321);
    drain("stop_err");

    // 5: 4-clk low glitch on idle line
    gap(20);
    rx = 1'b0;
    repeat (4) @(negedge clk);
    gap(40);
    check("glitch_state", dbg_state, 0);
    send_frame(8'hFF, 1'b0);
    gap(7);
    send_frame(8'h00, 1'b0);
    exp_q.push_back(16'h00FF);
    drain("glitch");

    // 6: reset during data bits of the second byte
    gap(10);
    send_frame(8'h11, 1'b0);
    gap(3);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    rx = 1'b1;
    rstn = 1'b1;
    repeat (2) @(negedge clk);
    check("midreset_m_data", m_data, 0);
    check("midreset_state", dbg_state, 0);
    rstn = 1'b0;
    gap(20);
    send_frame(8'hBE, 1'b0);
    gap(9);
    send_frame(8'hEF, 1'b0);
    exp_q.push_back(16'hEFBE);
    drain("midreset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
